// File: rtl/gate_response_checker.sv
// gate_response_checker
// Response side of the two-input gate stimulus flow. A vector {a,b} is latched
// on sample_valid. After SETTLE_CYCLES clocks, the seven observed gate outputs
// are compared against golden values derived from the latched vector.
// Per-check results, saturating pass/fail statistics, vector coverage and the
// first failing vector are kept for the bench to read.
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_valid,
    input  logic             a,
    input  logic             b,
    input  logic             and_g,
    input  logic             or_g,
    input  logic             not_g,
    input  logic             nand_g,
    input  logic             nor_g,
    input  logic             xor_g,
    input  logic             xnor_g,
    input  logic             clear,
    output logic             busy,
    output logic             check_valid,
    output logic             check_pass,
    output logic [6:0]       mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [3:0]       coverage,
    output logic             all_covered,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid,
    output logic             overrun
);

    // The down-counter only ever holds values up to SETTLE_CYCLES-1.
    localparam int CTR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CTR_W-1:0] SETTLE_LOAD =
        (SETTLE_CYCLES > 0) ? CTR_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        COMPARE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CTR_W-1:0] settle_cnt, settle_cnt_nxt;
    logic             capture;
    logic             do_compare;
    logic [1:0]       vec_q;
    logic [6:0]       golden;
    logic [6:0]       observed;
    logic [6:0]       mismatch_now;

    // Next-state logic; clear aborts any check in flight and blocks capture.
    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        capture        = 1'b0;
        if (clear) begin
            state_nxt      = IDLE;
            settle_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        capture = 1'b1;
                        if (SETTLE_CYCLES == 0) begin
                            state_nxt = COMPARE;
                        end else begin
                            state_nxt      = SETTLE;
                            settle_cnt_nxt = SETTLE_LOAD;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) begin
                        state_nxt = COMPARE;
                    end else begin
                        settle_cnt_nxt = settle_cnt - 1'b1;
                    end
                end
                COMPARE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    // Hold the applied vector so golden values ignore later input changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= 2'b00;
        end else if (capture) begin
            vec_q <= {a, b};
        end
    end

    // Golden gate values from the latched vector, packed in mismatch bit order.
    always_comb begin
        golden = {~(vec_q[1] ^ vec_q[0]), vec_q[1] ^ vec_q[0],
                  ~(vec_q[1] | vec_q[0]), ~(vec_q[1] & vec_q[0]),
                  ~vec_q[1], vec_q[1] | vec_q[0], vec_q[1] & vec_q[0]};
        observed     = {xnor_g, xor_g, nor_g, nand_g, not_g, or_g, and_g};
        mismatch_now = observed ^ golden;
    end

    assign do_compare  = (state == COMPARE) && !clear;
    assign busy        = (state != IDLE);
    assign all_covered = &coverage;

    // Register check results and update statistics when a compare completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            check_valid      <= 1'b0;
            check_pass       <= 1'b0;
            mismatch         <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            coverage         <= '0;
            first_fail_vec   <= 2'b00;
            first_fail_valid <= 1'b0;
        end else if (clear) begin
            check_valid      <= 1'b0;
            check_pass       <= 1'b0;
            mismatch         <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            coverage         <= '0;
            first_fail_vec   <= 2'b00;
            first_fail_valid <= 1'b0;
        end else begin
            check_valid <= do_compare;
            if (do_compare) begin
                check_pass      <= (mismatch_now == '0);
                mismatch        <= mismatch_now;
                coverage[vec_q] <= 1'b1;
                if (mismatch_now == '0) begin
                    if (pass_cnt != CNT_MAX) begin
                        pass_cnt <= pass_cnt + 1'b1;
                    end
                end else begin
                    if (fail_cnt != CNT_MAX) begin
                        fail_cnt <= fail_cnt + 1'b1;
                    end
                    if (!first_fail_valid) begin
                        first_fail_vec   <= vec_q;
                        first_fail_valid <= 1'b1;
                    end
                end
            end
        end
    end

    // Sticky flag for strobes that arrive while a check is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (clear) begin
            overrun <= 1'b0;
        end else if (sample_valid && busy) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker
// Bench for gate_response_checker: a default instance (SETTLE_CYCLES=2, CNT_W=8)
// with a gate model that can have xor stuck at 0, and a second instance
// (SETTLE_CYCLES=0, CNT_W=2) for zero-settle timing and counter saturation.
module tb_gate_response_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 signals
    logic       rst0_n, sv0, a0, b0, clear0, ga0, gb0, xor_fault;
    logic       busy0, cv0, cp0, ac0, ffvv0, ovr0;
    logic [6:0] mis0;
    logic [7:0] pc0, fc0;
    logic [3:0] cov0;
    logic [1:0] ffv0;

    // Instance 1 signals
    logic       rst1_n, sv1, a1, b1, clear1;
    logic       busy1, cv1, cp1, ac1, ffvv1, ovr1;
    logic [6:0] mis1;
    logic [1:0] pc1, fc1;
    logic [3:0] cov1;
    logic [1:0] ffv1;

    gate_response_checker #(.SETTLE_CYCLES(2), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst0_n), .sample_valid(sv0), .a(a0), .b(b0),
        .and_g(ga0 & gb0), .or_g(ga0 | gb0), .not_g(~ga0),
        .nand_g(~(ga0 & gb0)), .nor_g(~(ga0 | gb0)),
        .xor_g(xor_fault ? 1'b0 : (ga0 ^ gb0)), .xnor_g(~(ga0 ^ gb0)),
        .clear(clear0), .busy(busy0), .check_valid(cv0), .check_pass(cp0),
        .mismatch(mis0), .pass_cnt(pc0), .fail_cnt(fc0), .coverage(cov0),
        .all_covered(ac0), .first_fail_vec(ffv0), .first_fail_valid(ffvv0),
        .overrun(ovr0)
    );

    gate_response_checker #(.SETTLE_CYCLES(0), .CNT_W(2)) dut1 (
        .clk(clk), .rst_n(rst1_n), .sample_valid(sv1), .a(a1), .b(b1),
        .and_g(a1 & b1), .or_g(a1 | b1), .not_g(~a1),
        .nand_g(~(a1 & b1)), .nor_g(~(a1 | b1)),
        .xor_g(a1 ^ b1), .xnor_g(~(a1 ^ b1)),
        .clear(clear1), .busy(busy1), .check_valid(cv1), .check_pass(cp1),
        .mismatch(mis1), .pass_cnt(pc1), .fail_cnt(fc1), .coverage(cov1),
        .all_covered(ac1), .first_fail_vec(ffv1), .first_fail_valid(ffvv1),
        .overrun(ovr1)
    );

    typedef struct {
        logic       pass;
        logic [6:0] mis;
        int         due;
    } exp_t;

    typedef struct {
        logic       a;
        logic       b;
        logic       fault;
        logic       pass;
        logic [6:0] mis;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   pulses0 = 0;
    int   pulses1 = 0;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    // Scoreboard for instance 0: every check_valid must match the oldest expectation.
    always @(negedge clk) begin
        if (cv0) begin
            pulses0++;
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_check_valid0: got check_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e0 = q0.pop_front();
                chk("latency0", cyc, e0.due);
                chk("check_pass0", {31'b0, cp0}, {31'b0, e0.pass});
                chk("mismatch0", {25'b0, mis0}, {25'b0, e0.mis});
                chk("busy_in_cv0", {31'b0, busy0}, 32'd0);
            end
        end
    end

    // Scoreboard for instance 1.
    always @(negedge clk) begin
        if (cv1) begin
            pulses1++;
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_check_valid1: got check_valid=1 at cycle %0d, expected none", cyc);
            end else begin
                e1 = q1.pop_front();
                chk("latency1", cyc, e1.due);
                chk("check_pass1", {31'b0, cp1}, {31'b0, e1.pass});
                chk("mismatch1", {25'b0, mis1}, {25'b0, e1.mis});
                chk("busy_in_cv1", {31'b0, busy1}, 32'd0);
            end
        end
    end

    task automatic drive0(input logic va, input logic vb, input logic f,
                          input logic p, input logic [6:0] m);
        @(negedge clk);
        a0 = va; b0 = vb; ga0 = va; gb0 = vb; xor_fault = f; sv0 = 1'b1;
        q0.push_back('{pass: p, mis: m, due: cyc + 1 + 2 + 1});
        @(negedge clk);
        sv0 = 1'b0;
    endtask

    task automatic drive1(input logic va, input logic vb);
        @(negedge clk);
        a1 = va; b1 = vb; sv1 = 1'b1;
        q1.push_back('{pass: 1'b1, mis: 7'd0, due: cyc + 1 + 0 + 1});
        @(negedge clk);
        sv1 = 1'b0;
    endtask

    task automatic wait_done0();
        for (int i = 0; i < 50 && q0.size() != 0; i++) @(negedge clk);
        if (q0.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout0: got %0d pending checks, expected 0", q0.size());
            q0.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done1();
        for (int i = 0; i < 50 && q1.size() != 0; i++) @(negedge clk);
        if (q1.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL timeout1: got %0d pending checks, expected 0", q1.size());
            q1.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    initial begin
        int p;
        rst0_n = 1'b0; sv0 = 1'b0; a0 = 1'b0; b0 = 1'b0; clear0 = 1'b0;
        ga0 = 1'b0; gb0 = 1'b0; xor_fault = 1'b0;
        rst1_n = 1'b0; sv1 = 1'b0; a1 = 1'b0; b1 = 1'b0; clear1 = 1'b0;

        tbl[0] = '{a: 1'b0, b: 1'b0, fault: 1'b0, pass: 1'b1, mis: 7'b0000000};
        tbl[1] = '{a: 1'b0, b: 1'b1, fault: 1'b0, pass: 1'b1, mis: 7'b0000000};
        tbl[2] = '{a: 1'b1, b: 1'b0, fault: 1'b0, pass: 1'b1, mis: 7'b0000000};
        tbl[3] = '{a: 1'b1, b: 1'b1, fault: 1'b0, pass: 1'b1, mis: 7'b0000000};
        tbl[4] = '{a: 1'b1, b: 1'b0, fault: 1'b1, pass: 1'b0, mis: 7'b0100000};
        tbl[5] = '{a: 1'b0, b: 1'b1, fault: 1'b1, pass: 1'b0, mis: 7'b0100000};

        // Reset held for 3 cycles, then released.
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        @(negedge clk);
        chk("reset_busy0", {31'b0, busy0}, 32'd0);
        chk("reset_outs0", {cv0, cp0, mis0, pc0, fc0, cov0, ac0, ffv0, ffvv0, ovr0}, 32'd0);
        chk("reset_outs1", {cv1, cp1, busy1, mis1, pc1, fc1, cov1, ac1, ffv1, ffvv1, ovr1}, 32'd0);

        // Table-driven vectors on instance 0.
        for (int i = 0; i < 6; i++) begin
            drive0(tbl[i].a, tbl[i].b, tbl[i].fault, tbl[i].pass, tbl[i].mis);
            wait_done0();
            if (i == 3) begin
                chk("pass_cnt_4ok", {24'b0, pc0}, 32'd4);
                chk("fail_cnt_4ok", {24'b0, fc0}, 32'd0);
                chk("coverage_4ok", {28'b0, cov0}, 32'hF);
                chk("all_covered", {31'b0, ac0}, 32'd1);
                chk("ffvalid_4ok", {31'b0, ffvv0}, 32'd0);
            end
            if (i == 4) begin
                chk("fail_cnt_1", {24'b0, fc0}, 32'd1);
                chk("ffvec_1", {30'b0, ffv0}, 32'd2);
                chk("ffvalid_1", {31'b0, ffvv0}, 32'd1);
            end
            if (i == 5) begin
                chk("fail_cnt_2", {24'b0, fc0}, 32'd2);
                chk("ffvec_kept", {30'b0, ffv0}, 32'd2);
            end
        end

        // Second strobe one cycle into SETTLE with a different vector.
        xor_fault = 1'b0;
        p = pulses0;
        @(negedge clk);
        a0 = 1'b1; b0 = 1'b1; ga0 = 1'b1; gb0 = 1'b1; sv0 = 1'b1;
        q0.push_back('{pass: 1'b1, mis: 7'd0, due: cyc + 1 + 2 + 1});
        @(negedge clk);
        a0 = 1'b0; b0 = 1'b0;
        @(negedge clk);
        sv0 = 1'b0;
        wait_done0();
        repeat (4) @(negedge clk);
        chk("overrun_pulses", pulses0 - p, 32'd1);
        chk("overrun_flag", {31'b0, ovr0}, 32'd1);
        chk("overrun_pass_cnt", {24'b0, pc0}, 32'd5);

        // clear together with sample_valid: clear wins, statistics zeroed.
        @(negedge clk);
        a0 = 1'b0; b0 = 1'b1; sv0 = 1'b1; clear0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0; clear0 = 1'b0;
        chk("clr_sv_busy", {31'b0, busy0}, 32'd0);
        chk("clr_stats", {cp0, mis0, pc0, fc0, cov0, ffvv0, ovr0}, 32'd0);

        // clear one cycle into SETTLE aborts the check.
        drive0(1'b0, 1'b1, 1'b0, 1'b1, 7'd0);
        wait_done0();
        chk("pre_clear_pass", {24'b0, pc0}, 32'd1);
        p = pulses0;
        @(negedge clk);
        a0 = 1'b1; b0 = 1'b0; ga0 = 1'b1; gb0 = 1'b0; sv0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0; clear0 = 1'b1;
        @(negedge clk);
        clear0 = 1'b0;
        chk("abort_clr_busy", {31'b0, busy0}, 32'd0);
        repeat (5) @(negedge clk);
        chk("abort_clr_pulses", pulses0 - p, 32'd0);
        chk("abort_clr_stats", {pc0, fc0, cov0}, 32'd0);

        // rst_n pulsed low mid-SETTLE aborts the check.
        drive0(1'b1, 1'b1, 1'b0, 1'b1, 7'd0);
        wait_done0();
        chk("pre_rst_cov", {28'b0, cov0}, 32'h8);
        p = pulses0;
        @(negedge clk);
        a0 = 1'b0; b0 = 1'b0; ga0 = 1'b0; gb0 = 1'b0; sv0 = 1'b1;
        @(negedge clk);
        sv0 = 1'b0;
        #2 rst0_n = 1'b0;
        #1 chk("abort_rst_busy", {31'b0, busy0}, 32'd0);
        @(negedge clk);
        rst0_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_rst_pulses", pulses0 - p, 32'd0);
        chk("abort_rst_stats", {busy0, pc0, fc0, cov0}, 32'd0);

        // Instance 1: zero settle and 2-bit saturation.
        drive1(1'b0, 1'b0); wait_done1();
        drive1(1'b0, 1'b1); wait_done1();
        drive1(1'b1, 1'b0); wait_done1();
        chk("sat_pass_cnt_3", {30'b0, pc1}, 32'd3);
        drive1(1'b1, 1'b1); wait_done1();
        drive1(1'b0, 1'b0); wait_done1();
        chk("sat_pulses", pulses1, 32'd5);
        chk("sat_pass_cnt", {30'b0, pc1}, 32'd3);
        chk("sat_fail_cnt", {30'b0, fc1}, 32'd0);
        chk("sat_coverage", {27'b0, ac1, cov1}, 32'h1F);
        chk("sat_misc", {ffv1, ffvv1, ovr1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
